uart_rx_param: RTL and testbench
================================

UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 Parameter CLK_FRE, default 50, system clock frequency in MHz.
REQ-002 Parameter BAUD_RATE, default 115200, serial bit rate.
REQ-003 Parameter DATA_BITS, default 8, legal 5..8, data bits per frame.
REQ-004 Parameter PARITY, default 0, 0=none, 1=odd, 2=even.
REQ-005 Parameter STOP_BITS, default 1, legal 1 or 2.
REQ-006 Parameter OVERSAMPLE, default 16, sample ticks per bit, legal 8 or 16.
REQ-007 Port clk, input, 1, the only clock; every flop uses its rising edge.
REQ-008 Port rst_n, input, 1, asynchronous active-low reset.
REQ-009 Port rx_pin, input, 1, asynchronous serial line, idles high.
REQ-010 Port rx_data, output, DATA_BITS, received word, LSB first on the line.
REQ-011 Port rx_data_valid, output, 1, rx_data and error flags are held valid.
REQ-012 Port rx_data_ready, input, 1, consumer accepts the word when valid and ready are both 1.
REQ-013 Port parity_err, output, 1, parity mismatch for the held word.
REQ-014 Port frame_err, output, 1, a stop bit sampled low for the held word.
REQ-015 Port overrun, output, 1, one-cycle pulse when a completed frame is discarded.

Function
REQ-016 rx_pin SHALL pass through a 2-flop synchroniser; all decoding SHALL use the synchronised value.
REQ-017 The tick divisor SHALL be CLK_FRE*1000000/(BAUD_RATE*OVERSAMPLE), truncated: 27 at the defaults.
REQ-018 The tick counter SHALL be cleared on entry to START, so bit timing is aligned to the start edge.
REQ-019 States SHALL be IDLE, START, DATA, PARITY, STOP; PARITY is skipped when PARITY=0.
REQ-020 In IDLE, a synchronised 1-to-0 transition SHALL move the block to START.
REQ-021 Each bit value SHALL be the 2-of-3 majority of samples at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1.
REQ-022 In START, a majority of 1 SHALL be a false start: return to IDLE and emit no output.
REQ-023 DATA SHALL capture exactly DATA_BITS bits, LSB first, one per OVERSAMPLE ticks.
REQ-024 Parity SHALL be checked over the DATA_BITS data bits: odd means the count of ones including the parity bit is odd; even means that count is even.
REQ-025 STOP SHALL sample STOP_BITS stop bits; frame_err SHALL be set if any stop bit majority is 0.
REQ-026 The frame SHALL complete at the majority-sample point of the last stop bit; the block SHALL then return to IDLE immediately, so a back-to-back start edge is not missed.
REQ-027 On completion with rx_data_valid=0, or with rx_data_valid=1 and rx_data_ready=1 in the same cycle, the block SHALL load rx_data, parity_err and frame_err and drive rx_data_valid=1 on the next cycle.
REQ-028 On completion with rx_data_valid=1 and rx_data_ready=0, the new frame SHALL be dropped, the held word SHALL be unchanged, and overrun SHALL pulse for 1 cycle.
REQ-029 A handshake (rx_data_valid=1 and rx_data_ready=1) with no completion in the same cycle SHALL clear rx_data_valid on the next cycle; rx_data and the flags SHALL hold their last values.
REQ-030 A frame with errors SHALL still be delivered, with its flags set.

Reset
REQ-031 Asserting rst_n low SHALL asynchronously set state=IDLE, synchroniser flops=1, all counters=0, rx_data=0, rx_data_valid=0, parity_err=0, frame_err=0 and overrun=0.
REQ-032 Reset asserted mid-frame SHALL abandon the frame; after release, the block SHALL wait in IDLE for a fresh falling edge and emit no output for the abandoned frame.

Structure
REQ-033 The state enum, the parity encodings (NONE/ODD/EVEN) and the divisor function SHALL live in shared package uart_pkg, for reuse by a matching transmitter.
REQ-034 The tick generator SHALL be sub-module uart_baud_tick, with parameters for divisor and oversample and a tick output pulse plus an index output.

Verification
REQ-035 Defaults, line frame 0x55 8N1 -> rx_data=0x55, valid=1, parity_err=0, frame_err=0, valid held until ready=1.
REQ-036 PARITY=2, frame 0xA3 sent with parity bit 1 (wrong) -> rx_data=0xA3, parity_err=1, frame_err=0.
REQ-037 Defaults, frame 0x0F with stop bit driven 0 -> rx_data=0x0F, frame_err=1.
REQ-038 rx_pin low for 5 clocks, then high -> false start, no valid, state returns to IDLE.
REQ-039 Frames 0x11 then 0x22 back-to-back with ready=0 -> rx_data stays 0x11, overrun pulses once, valid=1 throughout.
REQ-040 DATA_BITS=7, PARITY=1, STOP_BITS=2: frame 0x5A; rst_n pulsed low during bit 3, then frame 0x3C -> only 0x3C delivered, flags 0.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding, parity modes and divisor helper.
// Shared by the receiver and any matching transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // clocks per oversample tick, truncated
  function automatic int baud_div(
    input int clk_mhz,
    input int baud,
    input int os
  );
    return (clk_mhz * 1000000) / (baud * os);
  endfunction

endpackage

// File: rtl/uart_rx_param_if.sv
// uart_rx_param_if: received-word handshake bundle.
// master = receiver side, slave = consumer side.
interface uart_rx_param_if #(
  parameter int DATA_BITS = 8
);

  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_data_valid;
  logic                 rx_data_ready;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun;

  modport master (
    output rx_data,
    output rx_data_valid,
    output parity_err,
    output frame_err,
    output overrun,
    input  rx_data_ready
  );

  modport slave (
    input  rx_data,
    input  rx_data_valid,
    input  parity_err,
    input  frame_err,
    input  overrun,
    output rx_data_ready
  );

endinterface

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: oversample tick pulse and tick index within a bit.
// Held at zero while clr is high so timing aligns to the start edge.
module uart_baud_tick #(
  parameter  int DIV        = 27,
  parameter  int OVERSAMPLE = 16,
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1,
  localparam int IW = $clog2(OVERSAMPLE)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  output logic          tick,
  output logic [IW-1:0] idx
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          wrap;

  // divide the clock, advance the index once per tick
  always_comb begin
    wrap  = (cnt_q == CW'(DIV - 1));
    cnt_d = wrap ? '0 : cnt_q + 1'b1;
    idx_d = wrap ? idx_q + 1'b1 : idx_q;
    if (clr) begin
      cnt_d = '0;
      idx_d = '0;
    end
  end

  // counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  assign tick = wrap & ~clr;
  assign idx  = idx_q;

endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampling UART receiver with majority voting,
// optional parity, 1/2 stop bits and a one-deep valid/ready output.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLK_FRE    = 50,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            rx_pin,
  uart_rx_param_if.master rx_if
);

  localparam int DIV = baud_div(CLK_FRE, BAUD_RATE, OVERSAMPLE);
  localparam int IW  = $clog2(OVERSAMPLE);
  localparam logic [IW-1:0] I_S0  = IW'(OVERSAMPLE / 2 - 1);
  localparam logic [IW-1:0] I_S1  = IW'(OVERSAMPLE / 2);
  localparam logic [IW-1:0] I_MJ  = IW'(OVERSAMPLE / 2 + 1);
  localparam logic [IW-1:0] I_END = IW'(OVERSAMPLE - 1);

  uart_state_t state_q, state_d;

  logic sync1_q, sync2_q, prev_q;
  logic tick;
  logic [IW-1:0] idx;

  logic s0_q, s0_d, s1_q, s1_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [0:0] stop_cnt_q, stop_cnt_d;
  logic par_q, par_d, fe_q, fe_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic valid_q, valid_d, perr_q, perr_d;
  logic ferr_q, ferr_d, ovr_q, ovr_d;

  logic fall, maj_pt, bit_end, maj;
  logic last_data, last_stop, done;
  logic ones, perr_new;

  uart_baud_tick #(
    .DIV       (DIV),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (state_q == ST_IDLE),
    .tick (tick),
    .idx  (idx)
  );

  assign fall      = prev_q & ~sync2_q;
  assign maj_pt    = tick & (idx == I_MJ);
  assign bit_end   = tick & (idx == I_END);
  assign maj       = (s0_q & s1_q) | (s0_q & sync2_q)
                   | (s1_q & sync2_q);
  assign last_data = (bit_cnt_q == 3'(DATA_BITS - 1));
  assign last_stop = (stop_cnt_q == 1'(STOP_BITS - 1));
  assign done      = (state_q == ST_STOP) & maj_pt & last_stop;
  assign ones      = ^shift_q ^ par_q;
  assign perr_new  = (PARITY == PAR_ODD)  ? ~ones :
                     (PARITY == PAR_EVEN) ?  ones : 1'b0;

  // line synchroniser, edge history and FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= ST_IDLE;
    end else begin
      sync1_q <= rx_pin;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      state_q <= state_d;
    end
  end

  // next-state: last stop bit exits at its vote point
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:
        if (fall) state_d = ST_START;
      ST_START:
        if (maj_pt && maj) state_d = ST_IDLE;
        else if (bit_end) state_d = ST_DATA;
      ST_DATA:
        if (bit_end && last_data)
          state_d = (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
      ST_PARITY:
        if (bit_end) state_d = ST_STOP;
      ST_STOP:
        if (done) state_d = ST_IDLE;
      default:
        state_d = ST_IDLE;
    endcase
  end

  // datapath and output handshake
  always_comb begin
    s0_d       = s0_q;
    s1_d       = s1_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    par_d      = par_q;
    fe_d       = fe_q;
    data_d     = data_q;
    valid_d    = valid_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    ovr_d      = 1'b0;
    if (tick && idx == I_S0) s0_d = sync2_q;
    if (tick && idx == I_S1) s1_d = sync2_q;
    unique case (state_q)
      ST_IDLE: begin
        bit_cnt_d  = '0;
        stop_cnt_d = '0;
        fe_d       = 1'b0;
      end
      ST_DATA: begin
        if (maj_pt)
          shift_d = {maj, shift_q[DATA_BITS-1:1]};
        if (bit_end && !last_data)
          bit_cnt_d = bit_cnt_q + 1'b1;
      end
      ST_PARITY:
        if (maj_pt) par_d = maj;
      ST_STOP: begin
        if (maj_pt && !maj) fe_d = 1'b1;
        if (bit_end) stop_cnt_d = stop_cnt_q + 1'b1;
      end
      default: ;
    endcase
    if (done && (!valid_q || rx_if.rx_data_ready)) begin
      data_d  = shift_q;
      perr_d  = perr_new;
      ferr_d  = fe_q | ~maj;
      valid_d = 1'b1;
    end else if (done) begin
      ovr_d = 1'b1;
    end else if (valid_q && rx_if.rx_data_ready) begin
      valid_d = 1'b0;
    end
  end

  // datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_q       <= 1'b0;
      s1_q       <= 1'b0;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= '0;
      par_q      <= 1'b0;
      fe_q       <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      s0_q       <= s0_d;
      s1_q       <= s1_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      par_q      <= par_d;
      fe_q       <= fe_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
    end
  end

  assign rx_if.rx_data       = data_q;
  assign rx_if.rx_data_valid = valid_q;
  assign rx_if.parity_err    = perr_q;
  assign rx_if.frame_err     = ferr_q;
  assign rx_if.overrun       = ovr_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: three receiver configurations driven in parallel,
// words checked against a per-instance expected-word queue.
module tb_uart_rx_param;
  import uart_pkg::*;

  localparam int DIV_TB = 27;
  localparam int BIT    = DIV_TB * 16;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic       stop_v;
    logic       exp_ferr;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n   [3];
  logic rx_line [3];
  logic ready   [3];

  int total  = 0;
  int passed = 0;
  int ovr_cnt [3];
  int drop_a = 0;
  bit watch_a = 1'b0;

  exp_t qa[$], qb[$], qc[$];
  exp_t ea, eb, ec;

  uart_rx_param_if #(.DATA_BITS(8)) if_a ();
  uart_rx_param_if #(.DATA_BITS(8)) if_b ();
  uart_rx_param_if #(.DATA_BITS(7)) if_c ();

  assign if_a.rx_data_ready = ready[0];
  assign if_b.rx_data_ready = ready[1];
  assign if_c.rx_data_ready = ready[2];

  uart_rx_param dut_a (
    .clk(clk), .rst_n(rst_n[0]),
    .rx_pin(rx_line[0]), .rx_if(if_a.master)
  );

  uart_rx_param #(.PARITY(2)) dut_b (
    .clk(clk), .rst_n(rst_n[1]),
    .rx_pin(rx_line[1]), .rx_if(if_b.master)
  );

  uart_rx_param #(
    .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)
  ) dut_c (
    .clk(clk), .rst_n(rst_n[2]),
    .rx_pin(rx_line[2]), .rx_if(if_c.master)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  function automatic int qsize(input int l);
    case (l)
      0: return qa.size();
      1: return qb.size();
      default: return qc.size();
    endcase
  endfunction

  task automatic push(input int l, input exp_t e);
    case (l)
      0: qa.push_back(e);
      1: qb.push_back(e);
      default: qc.push_back(e);
    endcase
  endtask

  task automatic send_bit(input int l, input logic v);
    rx_line[l] = v;
    repeat (BIT) @(posedge clk);
    #2;
  endtask

  task automatic send_frame(input int l, input logic [7:0] d,
                            input int nb, input int par,
                            input logic flip, input int nstop,
                            input logic [1:0] sv, input int gap);
    logic p;
    p = 1'b0;
    send_bit(l, 1'b0);
    for (int i = 0; i < nb; i++) begin
      send_bit(l, d[i]);
      p ^= d[i];
    end
    if (par != 0) send_bit(l, ((par == 1) ? ~p : p) ^ flip);
    for (int i = 0; i < nstop; i++) send_bit(l, sv[i]);
    rx_line[l] = 1'b1;
    repeat (gap) send_bit(l, 1'b1);
  endtask

  task automatic wait_empty(input int l, input string nm);
    for (int n = 0; n < 2 * BIT; n++) begin
      if (qsize(l) == 0) break;
      @(posedge clk);
    end
    @(posedge clk);
    #2;
    chk(nm, 32'(qsize(l)), 32'd0);
  endtask

  // scoreboard monitors: compare at the cycle before the handshake edge
  always @(negedge clk) begin
    if (if_a.rx_data_valid && if_a.rx_data_ready) begin
      if (qa.size() == 0) begin
        total++;
        $display("FAIL out_a: unexpected word %0h", if_a.rx_data);
      end else begin
        ea = qa.pop_front();
        chk("a_data", 32'(if_a.rx_data), 32'(ea.data));
        chk("a_perr", 32'(if_a.parity_err), 32'(ea.perr));
        chk("a_ferr", 32'(if_a.frame_err), 32'(ea.ferr));
      end
    end
    if (if_a.overrun) ovr_cnt[0]++;
    if (watch_a && !if_a.rx_data_valid) drop_a++;
  end

  always @(negedge clk) begin
    if (if_b.rx_data_valid && if_b.rx_data_ready) begin
      if (qb.size() == 0) begin
        total++;
        $display("FAIL out_b: unexpected word %0h", if_b.rx_data);
      end else begin
        eb = qb.pop_front();
        chk("b_data", 32'(if_b.rx_data), 32'(eb.data));
        chk("b_perr", 32'(if_b.parity_err), 32'(eb.perr));
        chk("b_ferr", 32'(if_b.frame_err), 32'(eb.ferr));
      end
    end
    if (if_b.overrun) ovr_cnt[1]++;
  end

  always @(negedge clk) begin
    if (if_c.rx_data_valid && if_c.rx_data_ready) begin
      if (qc.size() == 0) begin
        total++;
        $display("FAIL out_c: unexpected word %0h", if_c.rx_data);
      end else begin
        ec = qc.pop_front();
        chk("c_data", 32'(if_c.rx_data), 32'(ec.data));
        chk("c_perr", 32'(if_c.parity_err), 32'(ec.perr));
        chk("c_ferr", 32'(if_c.frame_err), 32'(ec.ferr));
      end
    end
    if (if_c.overrun) ovr_cnt[2]++;
  end

  task automatic stream_a();
    vec_t tbl [5];
    bit held;
    tbl[0] = '{8'h55, 1'b1, 1'b0};
    tbl[1] = '{8'h00, 1'b1, 1'b0};
    tbl[2] = '{8'hFF, 1'b1, 1'b0};
    tbl[3] = '{8'hA5, 1'b1, 1'b0};
    tbl[4] = '{8'h0F, 1'b0, 1'b1};

    // 0x55 8N1, held until ready
    push(0, '{8'h55, 1'b0, 1'b0});
    send_frame(0, 8'h55, 8, 0, 1'b0, 1, 2'b11, 1);
    held = 1'b1;
    repeat (50) begin
      if (!if_a.rx_data_valid) held = 1'b0;
      @(posedge clk);
    end
    #2;
    chk("a_valid_held", 32'(held), 32'd1);
    chk("a_data_held", 32'(if_a.rx_data), 32'h55);
    chk("a_sb_pending", 32'(qsize(0)), 32'd1);
    ready[0] = 1'b1;
    @(posedge clk);
    #2;
    ready[0] = 1'b0;
    chk("a_valid_clr", 32'(if_a.rx_data_valid), 32'd0);
    chk("a_data_keep", 32'(if_a.rx_data), 32'h55);

    // table of frames with ready held high
    ready[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push(0, '{tbl[i].data, 1'b0, tbl[i].exp_ferr});
      send_frame(0, tbl[i].data, 8, 0, 1'b0, 1,
                 {1'b1, tbl[i].stop_v}, 1);
      wait_empty(0, "a_tbl_drain");
    end

    // false start: low for 5 clocks
    rx_line[0] = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    chk("a_fs_start", 32'(dut_a.state_q), 32'(ST_START));
    rx_line[0] = 1'b1;
    repeat (2 * BIT) @(posedge clk);
    #2;
    chk("a_fs_idle", 32'(dut_a.state_q), 32'(ST_IDLE));
    chk("a_fs_novalid", 32'(if_a.rx_data_valid), 32'd0);

    // back-to-back with ready low: second frame overruns
    ready[0] = 1'b0;
    ovr_cnt[0] = 0;
    push(0, '{8'h11, 1'b0, 1'b0});
    send_frame(0, 8'h11, 8, 0, 1'b0, 1, 2'b11, 0);
    watch_a = 1'b1;
    send_frame(0, 8'h22, 8, 0, 1'b0, 1, 2'b11, 1);
    watch_a = 1'b0;
    chk("a_b2b_data", 32'(if_a.rx_data), 32'h11);
    chk("a_b2b_ovr", 32'(ovr_cnt[0]), 32'd1);
    chk("a_b2b_drop", 32'(drop_a), 32'd0);
    chk("a_b2b_valid", 32'(if_a.rx_data_valid), 32'd1);
    ready[0] = 1'b1;
    wait_empty(0, "a_b2b_drain");
  endtask

  task automatic stream_b();
    ready[1] = 1'b1;
    push(1, '{8'hA3, 1'b1, 1'b0});
    send_frame(1, 8'hA3, 8, 2, 1'b1, 1, 2'b11, 1);
    wait_empty(1, "b_bad_par_drain");
    push(1, '{8'hA3, 1'b0, 1'b0});
    send_frame(1, 8'hA3, 8, 2, 1'b0, 1, 2'b11, 1);
    wait_empty(1, "b_good_par_drain");
    chk("b_no_ovr", 32'(ovr_cnt[1]), 32'd0);
  endtask

  task automatic stream_c();
    logic [7:0] d;
    ready[2] = 1'b1;
    d = 8'h5A;
    // abandon 0x5A with a reset pulse inside bit 3
    send_bit(2, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(2, d[i]);
    rx_line[2] = d[3];
    repeat (BIT / 2) @(posedge clk);
    #2;
    rst_n[2] = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("c_rst_state", 32'(dut_c.state_q), 32'(ST_IDLE));
    chk("c_rst_valid", 32'(if_c.rx_data_valid), 32'd0);
    rst_n[2] = 1'b1;
    rx_line[2] = 1'b1;
    repeat (2 * BIT) @(posedge clk);
    #2;
    chk("c_abandon_valid", 32'(if_c.rx_data_valid), 32'd0);
    chk("c_abandon_data", 32'(if_c.rx_data), 32'd0);
    push(2, '{8'h3C, 1'b0, 1'b0});
    send_frame(2, 8'h3C, 7, 1, 1'b0, 2, 2'b11, 1);
    wait_empty(2, "c_3c_drain");
    // second stop bit low
    push(2, '{8'h41, 1'b0, 1'b1});
    send_frame(2, 8'h41, 7, 1, 1'b0, 2, 2'b01, 1);
    wait_empty(2, "c_stop2_drain");
  endtask

  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog: run exceeded cycle budget");
    $fatal(1);
  end

  initial begin
    rst_n   = '{1'b0, 1'b0, 1'b0};
    rx_line = '{1'b1, 1'b1, 1'b1};
    ready   = '{1'b0, 1'b0, 1'b0};
    ovr_cnt = '{0, 0, 0};
    repeat (4) @(posedge clk);
    #2;
    chk("rst_valid", 32'(if_a.rx_data_valid), 32'd0);
    chk("rst_data", 32'(if_a.rx_data), 32'd0);
    chk("rst_perr", 32'(if_a.parity_err), 32'd0);
    chk("rst_ferr", 32'(if_a.frame_err), 32'd0);
    chk("rst_ovr", 32'(if_a.overrun), 32'd0);
    chk("rst_state", 32'(dut_a.state_q), 32'(ST_IDLE));
    chk("rst_sync", 32'(dut_a.sync2_q), 32'd1);
    rst_n = '{1'b1, 1'b1, 1'b1};
    repeat (4) @(posedge clk);
    #2;
    fork
      stream_a();
      stream_b();
      stream_c();
    join
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
